// File: rtl/sat_pkg.sv
// sat_pkg
// Shared encodings for the SAT clause datapath.
//   VAR_*        : two-bit variable value as carried on the variable-value bus
//   LIT_*        : two-bit literal polarity held per clause slot
//   slot_class_e : per-slot classification produced by the stage-1 classifier
//   classify_slot: maps (polarity, variable value) onto a slot class
package sat_pkg;

   localparam logic [1:0] VAR_FREE  = 2'b00;
   localparam logic [1:0] VAR_FALSE = 2'b01;
   localparam logic [1:0] VAR_TRUE  = 2'b10;
   localparam logic [1:0] VAR_CONF  = 2'b11;

   localparam logic [1:0] LIT_ABSENT = 2'b00;
   localparam logic [1:0] LIT_NEG    = 2'b01;
   localparam logic [1:0] LIT_POS    = 2'b10;

   typedef enum logic [2:0] {
      ABSENT = 3'd0,
      FREE   = 3'd1,
      FALSE  = 3'd2,
      TRUE   = 3'd3,
      CONF   = 3'd4
   } slot_class_e;

   // An absent slot (including the 11 polarity code) never contributes, so it
   // is checked before the variable value is looked at.
   function automatic slot_class_e classify_slot(input logic [1:0] pol,
                                                 input logic [1:0] val);
      slot_class_e cls;
      cls = ABSENT;
      if (pol == LIT_POS || pol == LIT_NEG) begin
         if (val == VAR_FREE) begin
            cls = FREE;
         end else if (val == VAR_CONF) begin
            cls = CONF;
         end else if ((pol == LIT_POS && val == VAR_TRUE) ||
                      (pol == LIT_NEG && val == VAR_FALSE)) begin
            cls = TRUE;
         end else begin
            cls = FALSE;
         end
      end
      return cls;
   endfunction

endpackage

// File: rtl/lit_slot.sv
// lit_slot
// One literal slot of a clause row: holds the slot's polarity and registers
// the stage-1 classification of that literal against the variable value.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : mark this slot absent (wins over wr_i)
//   wr_i         : write polarity when wr_idx_i addresses this slot
//   wr_idx_i     : slot index being written
//   wr_lit_i     : polarity to write (11 stored as absent)
//   eval_i       : capture a classification this cycle
//   var_value_i  : this slot's variable value
//   class_o      : registered slot class (slot_class_e encoding)
//   pos_o        : registered "slot was positive" flag, for the implied value
module lit_slot
   import sat_pkg::*;
#(
   parameter int IDX_W    = 3,
   parameter int SLOT_IDX = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             wr_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [1:0]       wr_lit_i,
   input  logic             eval_i,
   input  logic [1:0]       var_value_i,
   output logic [2:0]       class_o,
   output logic             pos_o
);

   logic [1:0]  pol_q;
   slot_class_e class_q;
   logic        pos_q;
   logic        wr_hit;

   assign wr_hit = wr_i && (wr_idx_i == IDX_W'(SLOT_IDX));

   // Polarity register; the undefined 11 code is normalised to absent so the
   // classifier only ever sees the three legal encodings.
   always_ff @(posedge clk) begin
      if (rst) begin
         pol_q <= LIT_ABSENT;
      end else if (clr_i) begin
         pol_q <= LIT_ABSENT;
      end else if (wr_hit) begin
         if (wr_lit_i == LIT_POS || wr_lit_i == LIT_NEG) begin
            pol_q <= wr_lit_i;
         end else begin
            pol_q <= LIT_ABSENT;
         end
      end
   end

   // Stage 1 reads the polarity register before a same-cycle write lands, so
   // an eval alongside a write classifies against the old polarity.
   always_ff @(posedge clk) begin
      if (rst) begin
         class_q <= ABSENT;
         pos_q   <= 1'b0;
      end else if (eval_i) begin
         class_q <= classify_slot(pol_q, var_value_i);
         pos_q   <= (pol_q == LIT_POS);
      end
   end

   assign class_o = class_q;
   assign pos_o   = pos_q;

endmodule

// File: rtl/clause_cell_n.sv
// clause_cell_n
// N-literal clause evaluator. Stage 1 (lit_slot instances) classifies each
// slot; stage 2 reduces the classes into free count, satisfied, conflict and
// a unit-implication request with a hold-until-ack handshake.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   clr_i, wr_i, wr_idx_i, wr_lit_i : slot polarity maintenance
//   var_value_i           : 2 bits per slot of current variable values
//   eval_i                : start an evaluation (pipelined, one per cycle)
//   done_o                : one-cycle pulse, results valid (eval + 2)
//   freelitcnt_o, clausesat_o, cclause_o : held clause results
//   imp_valid_o, imp_idx_o, imp_value_o  : unit implication request
//   imp_ack_i             : arbiter accepted the implication
module clause_cell_n
   import sat_pkg::*;
#(
   parameter int NUM_LITS = 8,
   parameter int IDX_W    = $clog2(NUM_LITS),
   parameter int CNT_W    = $clog2(NUM_LITS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  wr_i,
   input  logic [IDX_W-1:0]      wr_idx_i,
   input  logic [1:0]            wr_lit_i,
   input  logic [2*NUM_LITS-1:0] var_value_i,
   input  logic                  eval_i,
   output logic                  done_o,
   output logic [CNT_W-1:0]      freelitcnt_o,
   output logic                  clausesat_o,
   output logic                  cclause_o,
   output logic                  imp_valid_o,
   output logic [IDX_W-1:0]      imp_idx_o,
   output logic [1:0]            imp_value_o,
   input  logic                  imp_ack_i
);

   logic [2:0]          slot_cls [NUM_LITS];
   logic [NUM_LITS-1:0] slot_pos;
   logic                eval_q;

   for (genvar g = 0; g < NUM_LITS; g++) begin : g_slot
      lit_slot #(
         .IDX_W   (IDX_W),
         .SLOT_IDX(g)
      ) u_slot (
         .clk        (clk),
         .rst        (rst),
         .clr_i      (clr_i),
         .wr_i       (wr_i),
         .wr_idx_i   (wr_idx_i),
         .wr_lit_i   (wr_lit_i),
         .eval_i     (eval_i),
         .var_value_i(var_value_i[2*g +: 2]),
         .class_o    (slot_cls[g]),
         .pos_o      (slot_pos[g])
      );
   end

   logic             any_true;
   logic             any_conf;
   logic             any_present;
   logic [CNT_W-1:0] free_cnt;
   logic             found_free;
   logic [IDX_W-1:0] first_free;
   logic             first_pos;
   logic             cclause_c;
   logic             unit_c;

   // Stage-2 reduction: popcount of free slots plus a lowest-index encoder;
   // the encoder result only matters when exactly one slot is free.
   always_comb begin
      any_true    = 1'b0;
      any_conf    = 1'b0;
      any_present = 1'b0;
      free_cnt    = '0;
      found_free  = 1'b0;
      first_free  = '0;
      first_pos   = 1'b0;
      for (int i = 0; i < NUM_LITS; i++) begin
         if (slot_cls[i] != ABSENT) begin
            any_present = 1'b1;
         end
         if (slot_cls[i] == TRUE) begin
            any_true = 1'b1;
         end
         if (slot_cls[i] == CONF) begin
            any_conf = 1'b1;
         end
         if (slot_cls[i] == FREE) begin
            free_cnt = free_cnt + CNT_W'(1);
            if (!found_free) begin
               found_free = 1'b1;
               first_free = IDX_W'(i);
               first_pos  = slot_pos[i];
            end
         end
      end
      cclause_c = any_conf || (any_present && !any_true && (free_cnt == '0));
      unit_c    = !any_true && !cclause_c && (free_cnt == CNT_W'(1));
   end

   // Stage-2 result registers. A completing evaluation overrides a same-cycle
   // ack or clear; the implication target only changes when a new one is
   // raised, which keeps it stable while imp_valid_o is up.
   always_ff @(posedge clk) begin
      if (rst) begin
         eval_q       <= 1'b0;
         done_o       <= 1'b0;
         freelitcnt_o <= '0;
         clausesat_o  <= 1'b0;
         cclause_o    <= 1'b0;
         imp_valid_o  <= 1'b0;
         imp_idx_o    <= '0;
         imp_value_o  <= 2'b00;
      end else begin
         eval_q <= eval_i;
         done_o <= eval_q;
         if (eval_q) begin
            freelitcnt_o <= free_cnt;
            clausesat_o  <= any_true;
            cclause_o    <= cclause_c;
            if (unit_c) begin
               imp_valid_o <= 1'b1;
               imp_idx_o   <= first_free;
               imp_value_o <= first_pos ? VAR_TRUE : VAR_FALSE;
            end else begin
               imp_valid_o <= 1'b0;
            end
         end else if (clr_i || imp_ack_i) begin
            imp_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clause_cell_n.sv
// tb_clause_cell_n
// Self-checking bench for clause_cell_n with four slots. The index port is
// widened to 3 bits so that an out-of-range slot write can be exercised.
module tb_clause_cell_n;

   localparam int NL = 4;
   localparam int IW = 3;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr_i;
   logic          wr_i;
   logic [IW-1:0] wr_idx_i;
   logic [1:0]    wr_lit_i;
   logic [2*NL-1:0] var_value_i;
   logic          eval_i;
   logic          done_o;
   logic [CW-1:0] freelitcnt_o;
   logic          clausesat_o;
   logic          cclause_o;
   logic          imp_valid_o;
   logic [IW-1:0] imp_idx_o;
   logic [1:0]    imp_value_o;
   logic          imp_ack_i;

   clause_cell_n #(.NUM_LITS(NL), .IDX_W(IW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (clr_i),
      .wr_i        (wr_i),
      .wr_idx_i    (wr_idx_i),
      .wr_lit_i    (wr_lit_i),
      .var_value_i (var_value_i),
      .eval_i      (eval_i),
      .done_o      (done_o),
      .freelitcnt_o(freelitcnt_o),
      .clausesat_o (clausesat_o),
      .cclause_o   (cclause_o),
      .imp_valid_o (imp_valid_o),
      .imp_idx_o   (imp_idx_o),
      .imp_value_o (imp_value_o),
      .imp_ack_i   (imp_ack_i)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: polarity per slot (0 absent, 1 neg, 2 pos) and
   // the clause outputs the design should currently be showing.
   int         pol [NL];
   int         e_cnt;
   bit         e_sat, e_ccl, e_impv;
   int         e_idx;
   logic [1:0] e_val;

   typedef struct {
      int         cnt;
      bit         sat;
      bit         ccl;
      bit         unit;
      int         idx;
      logic [1:0] val;
   } res_t;

   // Evaluates the clause straight from the literal rules.
   function automatic res_t model(input logic [2*NL-1:0] v);
      res_t r;
      int present, free, first;
      bit conf;
      logic [1:0] x;
      present = 0; free = 0; first = -1; conf = 0;
      r.sat = 0;
      for (int i = 0; i < NL; i++) begin
         x = v[2*i +: 2];
         if (pol[i] == 0) continue;
         present++;
         if (x == 2'b11) conf = 1;
         else if (x == 2'b00) begin
            free++;
            if (first < 0) first = i;
         end else if ((pol[i] == 2 && x == 2'b10) || (pol[i] == 1 && x == 2'b01)) r.sat = 1;
      end
      r.cnt  = free;
      r.ccl  = conf || (present > 0 && !r.sat && free == 0);
      r.unit = !r.sat && !r.ccl && free == 1;
      r.idx  = (first < 0) ? 0 : first;
      r.val  = (first >= 0 && pol[r.idx] == 2) ? 2'b10 : 2'b01;
      return r;
   endfunction

   function automatic void apply(input res_t r);
      e_cnt = r.cnt; e_sat = r.sat; e_ccl = r.ccl;
      if (r.unit) begin
         e_impv = 1; e_idx = r.idx; e_val = r.val;
      end else begin
         e_impv = 0;
      end
   endfunction

   function automatic logic [11:0] obs();
      return {done_o, freelitcnt_o, clausesat_o, cclause_o, imp_valid_o,
              imp_valid_o ? imp_idx_o : 3'd0, imp_valid_o ? imp_value_o : 2'd0};
   endfunction

   function automatic logic [11:0] expv(input bit d);
      return {d, 3'(e_cnt), e_sat, e_ccl, e_impv,
              e_impv ? 3'(e_idx) : 3'd0, e_impv ? e_val : 2'd0};
   endfunction

   function automatic logic [2*NL-1:0] mkv(input logic [1:0] s0, input logic [1:0] s1,
                                          input logic [1:0] s2, input logic [1:0] s3);
      return {s3, s2, s1, s0};
   endfunction

   // Stimulus helpers: all start and end just after a falling edge.
   task automatic write_slot(input int idx, input logic [1:0] lit);
      wr_i = 1; wr_idx_i = IW'(idx); wr_lit_i = lit;
      @(negedge clk);
      wr_i = 0;
      if (idx < NL) pol[idx] = (lit == 2'b01) ? 1 : (lit == 2'b10) ? 2 : 0;
   endtask

   task automatic run_eval(input logic [2*NL-1:0] v);
      res_t r;
      r = model(v);
      var_value_i = v; eval_i = 1;
      @(negedge clk);
      eval_i = 0;
      @(negedge clk);
      apply(r);
   endtask

   task automatic test_reset();
      rst = 1; clr_i = 0; wr_i = 0; wr_idx_i = 0; wr_lit_i = 0;
      var_value_i = 0; eval_i = 0; imp_ack_i = 0;
      for (int i = 0; i < NL; i++) pol[i] = 0;
      e_cnt = 0; e_sat = 0; e_ccl = 0; e_impv = 0; e_idx = 0; e_val = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      n_cmp++;
      if ({done_o, freelitcnt_o, clausesat_o, cclause_o, imp_valid_o, imp_idx_o, imp_value_o} !== 12'd0) begin
         n_bad++;
         $display("[TB] FAIL reset_outputs: got %b want 0", obs());
      end
   endtask

   task automatic test_unit_hold_ack();
      res_t r;
      logic [2*NL-1:0] v;
      write_slot(0, 2'b10);
      write_slot(1, 2'b01);
      write_slot(3, 2'b10);
      v = mkv(2'b00, 2'b10, 2'($urandom), 2'b01);
      r = model(v);
      var_value_i = v; eval_i = 1;
      @(negedge clk);
      eval_i = 0;
      n_cmp++;
      if (done_o !== 1'b0) begin
         n_bad++; $display("[TB] FAIL unit_early_done: got %b want 0", done_o);
      end
      @(negedge clk);
      apply(r);
      n_cmp++;
      if (obs() !== expv(1)) begin
         n_bad++; $display("[TB] FAIL unit_result: got %b want %b", obs(), expv(1));
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (obs() !== expv(0)) begin
            n_bad++; $display("[TB] FAIL unit_hold%0d: got %b want %b", k, obs(), expv(0));
         end
      end
      imp_ack_i = 1;
      @(negedge clk);
      imp_ack_i = 0;
      e_impv = 0;
      n_cmp++;
      if (imp_valid_o !== 1'b0) begin
         n_bad++; $display("[TB] FAIL unit_ack: got %b want 0", imp_valid_o);
      end
   endtask

   task automatic test_sat_conflict();
      logic [2*NL-1:0] vs [3];
      vs[0] = mkv(2'b10, 2'b10, 2'($urandom), 2'b01);
      vs[1] = mkv(2'b01, 2'b10, 2'($urandom), 2'b01);
      vs[2] = mkv(2'b00, 2'b11, 2'($urandom), 2'b00);
      for (int k = 0; k < 3; k++) begin
         run_eval(vs[k]);
         n_cmp++;
         if (obs() !== expv(1)) begin
            n_bad++; $display("[TB] FAIL satconf%0d: got %b want %b", k, obs(), expv(1));
         end
      end
      @(negedge clk);
      n_cmp++;
      if (obs() !== expv(0)) begin
         n_bad++; $display("[TB] FAIL satconf_hold: got %b want %b", obs(), expv(0));
      end
   endtask

   task automatic test_back_to_back();
      logic [2*NL-1:0] vs [3];
      res_t rs [3];
      for (int k = 0; k < 3; k++) begin
         vs[k] = 8'($urandom);
         rs[k] = model(vs[k]);
      end
      for (int c = 0; c < 6; c++) begin
         if (c >= 2 && c < 5) begin
            apply(rs[c-2]);
            n_cmp++;
            if (obs() !== expv(1)) begin
               n_bad++; $display("[TB] FAIL b2b%0d: got %b want %b", c - 2, obs(), expv(1));
            end
         end else if (c == 5) begin
            n_cmp++;
            if (done_o !== 1'b0) begin
               n_bad++; $display("[TB] FAIL b2b_extra_done: got %b want 0", done_o);
            end
         end
         if (c < 3) begin
            eval_i = 1; var_value_i = vs[c];
         end else begin
            eval_i = 0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_write_same_cycle();
      res_t r;
      logic [2*NL-1:0] v;
      v = mkv(2'b01, 2'b10, 2'b00, 2'b01);
      r = model(v);
      wr_i = 1; wr_idx_i = 3'd2; wr_lit_i = 2'b10;
      eval_i = 1; var_value_i = v;
      @(negedge clk);
      wr_i = 0; eval_i = 0; pol[2] = 2;
      @(negedge clk);
      apply(r);
      n_cmp++;
      if (obs() !== expv(1)) begin
         n_bad++; $display("[TB] FAIL wr_eval_old: got %b want %b", obs(), expv(1));
      end
      run_eval(v);
      n_cmp++;
      if (obs() !== expv(1)) begin
         n_bad++; $display("[TB] FAIL wr_eval_new: got %b want %b", obs(), expv(1));
      end
   endtask

   task automatic test_clr_wr();
      clr_i = 1; wr_i = 1; wr_idx_i = 3'd0; wr_lit_i = 2'b10;
      @(negedge clk);
      clr_i = 0; wr_i = 0;
      for (int i = 0; i < NL; i++) pol[i] = 0;
      e_impv = 0;
      n_cmp++;
      if (imp_valid_o !== 1'b0) begin
         n_bad++; $display("[TB] FAIL clr_imp: got %b want 0", imp_valid_o);
      end
      run_eval(8'($urandom));
      n_cmp++;
      if (obs() !== 12'b1_000_000_000_00) begin
         n_bad++; $display("[TB] FAIL clr_empty: got %b want %b", obs(), 12'b1_000_000_000_00);
      end
   endtask

   task automatic test_reset_inflight();
      write_slot(0, 2'b01);
      write_slot(1, 2'b10);
      run_eval(mkv(2'b00, 2'b01, 2'b00, 2'b00));
      n_cmp++;
      if (obs() !== expv(1)) begin
         n_bad++; $display("[TB] FAIL rst_setup: got %b want %b", obs(), expv(1));
      end
      eval_i = 1; var_value_i = 8'($urandom);
      @(negedge clk);
      eval_i = 0; rst = 1;
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < NL; i++) pol[i] = 0;
      e_cnt = 0; e_sat = 0; e_ccl = 0; e_impv = 0;
      n_cmp++;
      if ({done_o, freelitcnt_o, clausesat_o, cclause_o, imp_valid_o, imp_idx_o, imp_value_o} !== 12'd0) begin
         n_bad++; $display("[TB] FAIL rst_inflight_outputs: got %b want 0", obs());
      end
      @(negedge clk);
      n_cmp++;
      if (done_o !== 1'b0) begin
         n_bad++; $display("[TB] FAIL rst_inflight_done: got %b want 0", done_o);
      end
      write_slot(5, 2'b10);
      run_eval(8'h00);
      n_cmp++;
      if (obs() !== expv(1)) begin
         n_bad++; $display("[TB] FAIL wr_idx_oob: got %b want %b", obs(), expv(1));
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 60; it++) begin
         int nw;
         nw = $urandom_range(0, 2);
         for (int w = 0; w < nw; w++) write_slot($urandom_range(0, 7), 2'($urandom));
         if ($urandom_range(0, 9) == 0) begin
            clr_i = 1;
            @(negedge clk);
            clr_i = 0;
            for (int i = 0; i < NL; i++) pol[i] = 0;
            e_impv = 0;
         end
         run_eval(8'($urandom));
         n_cmp++;
         if (obs() !== expv(1)) begin
            n_bad++; $display("[TB] FAIL rand%0d: got %b want %b", it, obs(), expv(1));
         end
         if ($urandom_range(0, 1) == 1) begin
            imp_ack_i = 1;
            @(negedge clk);
            imp_ack_i = 0;
            e_impv = 0;
            n_cmp++;
            if (obs() !== expv(0)) begin
               n_bad++; $display("[TB] FAIL rand_ack%0d: got %b want %b", it, obs(), expv(0));
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_unit_hold_ack();
      test_sat_conflict();
      test_back_to_back();
      test_write_same_cycle();
      test_clr_wr();
      test_reset_inflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clause_cell_n.md
# clause_cell_n

Parametrised clause evaluator for the SAT engine: holds the polarity of up to NUM_LITS literals of one clause and evaluates them against current variable values. Each evaluation runs through a 2-stage pipeline and returns four results: free-literal count, clause-satisfied, conflict-clause, and a unit-implication request with a held handshake. It generalises the single-literal cell to an N-literal clause row and sits between the variable-value bus and the implication/conflict arbiter.

## Interface
- NUM_LITS, 8, literal slots per clause (≥2)
- IDX_W, $clog2(NUM_LITS), slot index width
- CNT_W, $clog2(NUM_LITS+1), free-count width
- clk  in  1  clock, single clock domain
- rst  in  1  synchronous, active-high reset
- clr_i  in  1  mark all slots absent
- wr_i  in  1  write one slot's polarity
- wr_idx_i  in  IDX_W  slot to write; values ≥NUM_LITS ignored
- wr_lit_i  in  2  polarity: 00 absent, 01 negative, 10 positive, 11 treated as absent
- var_value_i  in  2*NUM_LITS  per-slot variable value: 00 free, 01 false, 10 true, 11 conflict
- eval_i  in  1  start evaluation of current slots/values
- done_o  out  1  1-cycle pulse, results valid
- freelitcnt_o  out  CNT_W  present slots whose literal is free
- clausesat_o  out  1  some present literal true
- cclause_o  out  1  clause in conflict
- imp_valid_o  out  1  unit implication pending
- imp_idx_o  out  IDX_W  slot to imply
- imp_value_o  out  2  value to assign the variable (10 true / 01 false)
- imp_ack_i  in  1  arbiter accepted the implication

## Operation
- Slot classification, present slots only:
  - true: pos & var=10, or neg & var=01
  - false: pos & var=01, or neg & var=10
  - free: var=00
  - conflict-var: var=11
  - absent slots contribute nothing.
- clausesat = any true.
- freelitcnt = number of free slots; exact, no saturation.
- cclause:
  - asserted if any conflict-var slot;
  - otherwise asserted if ≥1 present slot, !sat and freelitcnt=0.
- Unit condition: !sat, !cclause, freelitcnt=1. Then imp_idx = the free slot, imp_value = 10 for pos, 01 for neg.
- Empty clause (no present slots): sat=0, cnt=0, cclause=0, no implication.
- Slot writes:
  - clr_i has priority over wr_i in the same cycle.
  - A write takes effect the following cycle.
  - An eval_i in the same cycle as a write sees the old polarity.
- imp_valid_o:
  - set with done_o when the unit condition holds;
  - cleared by imp_ack_i;
  - cleared by done_o with no unit condition;
  - cleared by clr_i.
- imp_idx_o and imp_value_o are stable while imp_valid_o=1.
- done_o and imp_ack_i in the same cycle: the new result wins.
- Reset:
  - all slots absent;
  - all outputs 0;
  - in-flight evaluations discarded, so no done_o for them.

## Timing
- Stage 1, cycle of eval_i: per-slot class registered from slot regs and var_value_i sampled that edge.
- Stage 2, next cycle: reduction and priority encode registered.
- done_o and all results appear 2 cycles after eval_i.
- Fully pipelined: eval_i may be asserted every cycle, one done_o per cycle, in order.
- freelitcnt_o, clausesat_o and cclause_o hold their last values between done_o pulses.
- clr_i during the pipeline does not alter in-flight results. It only clears imp_valid_o that cycle; a done_o on the next cycle may set it again.

## Structure
- Package sat_pkg:
  - var-value constants VAR_FREE/VAR_FALSE/VAR_TRUE/VAR_CONF;
  - polarity constants LIT_ABSENT/LIT_NEG/LIT_POS;
  - a slot-class enum (ABSENT, FREE, FALSE, TRUE, CONF).
- Sub-module lit_slot: polarity register, write/clear logic and registered stage-1 classifier. Instantiated NUM_LITS times via generate.
- Stage-2 reduction, popcount and lowest-index free-slot encoder live in clause_cell_n.

## Test plan
All scenarios use NUM_LITS=4.
- Slots {pos,neg,absent,pos}, var {00,10,xx,01}, eval:
  - done at +2;
  - cnt=1, sat=0, cclause=0;
  - imp_valid=1, idx=0, value=10.
  - Hold 3 cycles: imp stays set. imp_ack: imp_valid=0 next cycle.
- Same slots, var {10,10,xx,01}: cnt=0, sat=1, cclause=0, imp_valid=0.
- Var {01,10,xx,01}: cclause=1, sat=0. Var {00,11,xx,00}: cclause=1, cnt=2.
- Back-to-back eval on 3 cycles with differing var sets: three consecutive done pulses, results in order.
- Write slot 2 = pos with eval the same cycle: result ignores slot 2; the next eval counts it. clr_i+wr_i together: all slots absent, eval gives all-zero results.
- rst asserted one cycle after eval: no done_o, all outputs 0; wr_idx_i=5 ignored.
